// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux
// Description : Time-division demultiplexer. Collects CHANNELS beats of a
//               sync-marked frame into shadow storage and commits the whole
//               frame to out_data at once. Short or unsynced frames are
//               flagged on err and their partial data is discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux #(
   parameter int WIDTH    = 2,
   parameter int CHANNELS = 4,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic                      in_sync,
   input  logic [WIDTH-1:0]          in_data,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic                      frame_done,
   output logic                      err,
   output logic [SEL_W-1:0]          slot
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RECV = 1'b1;

   localparam logic [SEL_W-1:0] c_LAST_SLOT = SEL_W'(CHANNELS - 1);
   localparam logic [SEL_W-1:0] c_SLOT_ONE  = SEL_W'(1);

   // The last channel never needs shadow storage: its beat is merged
   // directly into out_data at commit time.
   localparam int SHADOW_W = (CHANNELS - 1) * WIDTH;

   logic [0:0]                state_q,      state_d;
   logic [SEL_W-1:0]          slot_q,       slot_d;
   logic [SHADOW_W-1:0]       shadow_q,     shadow_d;
   logic [CHANNELS*WIDTH-1:0] out_data_q,   out_data_d;
   logic                      frame_done_q, frame_done_d;
   logic                      err_q,        err_d;

   // Next-state logic: beat steering, frame commit and protocol checking
   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      shadow_d     = shadow_q;
      out_data_d   = out_data_q;
      frame_done_d = 1'b0;
      err_d        = 1'b0;

      if (in_valid) begin
         case (state_q)
            S_IDLE: begin
               if (in_sync) begin
                  shadow_d[WIDTH-1:0] = in_data;
                  slot_d              = c_SLOT_ONE;
                  state_d             = S_RECV;
               end else begin
                  // Beat outside any frame: drop it and flag
                  err_d = 1'b1;
               end
            end
            S_RECV: begin
               if (in_sync) begin
                  // Short frame: abandon the partial frame, restart at slot 0
                  err_d               = 1'b1;
                  shadow_d[WIDTH-1:0] = in_data;
                  slot_d              = c_SLOT_ONE;
               end else if (slot_q == c_LAST_SLOT) begin
                  out_data_d   = {in_data, shadow_q};
                  frame_done_d = 1'b1;
                  slot_d       = '0;
                  state_d      = S_IDLE;
               end else begin
                  for (int k = 1; k < CHANNELS - 1; k++) begin
                     if (slot_q == SEL_W'(k)) begin
                        shadow_d[k*WIDTH +: WIDTH] = in_data;
                     end
                  end
                  slot_d = slot_q + c_SLOT_ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               slot_d  = '0;
            end
         endcase
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         slot_q       <= '0;
         shadow_q     <= '0;
         out_data_q   <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         shadow_q     <= shadow_d;
         out_data_q   <= out_data_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign out_data   = out_data_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;
   assign slot       = slot_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux
// Description : Self-checking bench for tdm_demux (WIDTH=2, CHANNELS=4).
//               Directed frames plus randomized traffic against a queue-based
//               frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux;

   localparam int WIDTH    = 2;
   localparam int CHANNELS = 4;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      in_valid;
   logic                      in_sync;
   logic [WIDTH-1:0]          in_data;
   logic [CHANNELS*WIDTH-1:0] out_data;
   logic                      frame_done;
   logic                      err;
   logic [1:0]                slot;

   tdm_demux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_sync    (in_sync),
      .in_data    (in_data),
      .out_data   (out_data),
      .frame_done (frame_done),
      .err        (err),
      .slot       (slot)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int done_cyc[$];

   // Reference model: the beats of the frame collected so far
   logic [WIDTH-1:0] beats[$];
   logic [7:0]       exp_out  = '0;
   logic             exp_done = 1'b0;
   logic             exp_err  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out"},  32'(out_data),   32'(exp_out));
      check({tag, ".done"}, 32'(frame_done), 32'(exp_done));
      check({tag, ".err"},  32'(err),        32'(exp_err));
      check({tag, ".slot"}, 32'(slot),       32'(beats.size()));
   endtask

   task automatic model_step(input logic v, input logic s, input logic [WIDTH-1:0] d);
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (v) begin
         if (s) begin
            if (beats.size() != 0) exp_err = 1'b1;
            beats.delete();
            beats.push_back(d);
         end else if (beats.size() == 0) begin
            exp_err = 1'b1;
         end else begin
            beats.push_back(d);
            if (beats.size() == CHANNELS) begin
               exp_out  = {beats[3], beats[2], beats[1], beats[0]};
               exp_done = 1'b1;
               beats.delete();
            end
         end
      end
   endtask

   // One clock: drive at negedge, model at posedge, check at next negedge
   task automatic cycle(input logic v, input logic s, input logic [WIDTH-1:0] d, input string tag);
      in_valid = v;
      in_sync  = s;
      in_data  = d;
      @(posedge clk);
      model_step(v, s, d);
      @(negedge clk);
      cyc++;
      if (frame_done === 1'b1) done_cyc.push_back(cyc);
      check_all(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'(i), tag);
   endtask

   // Asynchronous assert mid-cycle, synchronous release at a negedge
   task automatic do_reset(input string tag);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      beats.delete();
      exp_out  = '0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      check_all({tag, ".async"});
      @(negedge clk);
      check_all({tag, ".held"});
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sync  = 1'b0;
      in_data  = '0;
      @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;
      idle(1, "post_reset");

      // Full frame 3,1,2,0 -> 8'h27
      cycle(1, 1, 2'd3, "full");
      cycle(1, 0, 2'd1, "full");
      cycle(1, 0, 2'd2, "full");
      cycle(1, 0, 2'd0, "full");
      check("full_value", 32'(out_data), 32'h27);
      idle(1, "full_after");
      do_reset("rst2");

      // Gapped frame with 0..3 idle cycles between beats
      cycle(1, 1, 2'd3, "gap");
      idle(2, "gap");
      cycle(1, 0, 2'd1, "gap");
      idle(3, "gap");
      cycle(1, 0, 2'd2, "gap");
      cycle(1, 0, 2'd0, "gap");
      check("gap_value", 32'(out_data), 32'h27);
      idle(1, "gap_after");

      // Short frame followed by full frame of 2s -> 8'hAA
      cycle(1, 1, 2'd3, "short");
      cycle(1, 0, 2'd1, "short");
      cycle(1, 1, 2'd2, "short");
      check("short_err", 32'(err), 32'h1);
      cycle(1, 0, 2'd2, "short");
      cycle(1, 0, 2'd2, "short");
      cycle(1, 0, 2'd2, "short");
      check("short_value", 32'(out_data), 32'hAA);
      idle(1, "short_after");

      // Unsynced beats in IDLE
      for (int i = 0; i < 3; i++) cycle(1, 0, 2'd1, "unsync");
      check("unsync_value", 32'(out_data), 32'hAA);

      // Reset mid-frame then frame of 1s -> 8'h55
      cycle(1, 1, 2'd3, "midrst");
      cycle(1, 0, 2'd1, "midrst");
      do_reset("midrst");
      cycle(1, 1, 2'd1, "midrst");
      cycle(1, 0, 2'd1, "midrst");
      cycle(1, 0, 2'd1, "midrst");
      cycle(1, 0, 2'd1, "midrst");
      check("midrst_value", 32'(out_data), 32'h55);
      idle(1, "midrst_after");

      // Back-to-back frames with no dead cycle
      done_cyc.delete();
      cycle(1, 1, 2'd3, "b2b");
      cycle(1, 0, 2'd1, "b2b");
      cycle(1, 0, 2'd2, "b2b");
      cycle(1, 0, 2'd0, "b2b");
      cycle(1, 1, 2'd2, "b2b");
      cycle(1, 0, 2'd2, "b2b");
      cycle(1, 0, 2'd2, "b2b");
      cycle(1, 0, 2'd2, "b2b");
      idle(2, "b2b");
      check("b2b_count", 32'(done_cyc.size()), 32'd2);
      if (done_cyc.size() == 2) check("b2b_gap", 32'(done_cyc[1] - done_cyc[0]), 32'd4);

      // Randomized traffic, with occasional mid-frame resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset("rnd_rst");
         end else begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                  2'($urandom_range(0, 3)), "rnd");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
